// File: rtl/count_monitor.sv
// Receive-side monitor for a step counter: recovers the step increment from the
// sampled count stream, declares lock, then flags prediction mismatches and wraps.
module count_monitor #(
    parameter int WIDTH      = 5,
    parameter int STEP_W     = 4,
    parameter int LOCK_COUNT = 3,
    parameter int ERR_LIMIT  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic [WIDTH-1:0]  count,
    output logic [STEP_W-1:0] step,
    output logic              locked,
    output logic              err,
    output logic              wrap,
    output logic [7:0]        err_count,
    output logic [1:0]        state
);

    localparam int MC_W = $clog2(LOCK_COUNT + 1);
    localparam int MS_W = $clog2(ERR_LIMIT + 1);
    localparam logic [WIDTH:0] MAX_STEP = (WIDTH + 1)'((1 << STEP_W) - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic step_legal(input logic [WIDTH-1:0] d);
        return (d != '0) && ({1'b0, d} <= MAX_STEP);
    endfunction

    state_t            state_p1, state_nxt;
    logic [WIDTH-1:0]  prev_p1, prev_nxt;
    logic [STEP_W-1:0] cand_p1, cand_nxt;
    logic [MC_W-1:0]   match_p1, match_nxt;
    logic [MS_W-1:0]   miss_p1, miss_nxt;
    logic [STEP_W-1:0] step_p1, step_nxt;
    logic              locked_p1, locked_nxt;
    logic              err_p1, err_nxt;
    logic              wrap_p1, wrap_nxt;
    logic [7:0]        errcnt_p1, errcnt_nxt;

    logic [WIDTH-1:0]  diff;
    logic [WIDTH-1:0]  pred;
    logic              legal;

    // Stage 0: difference and prediction from the previous sample
    assign diff  = count - prev_p1;
    assign pred  = prev_p1 + WIDTH'(step_p1);
    assign legal = step_legal(diff);

    always_comb begin
        state_nxt  = state_p1;
        prev_nxt   = prev_p1;
        cand_nxt   = cand_p1;
        match_nxt  = match_p1;
        miss_nxt   = miss_p1;
        step_nxt   = step_p1;
        locked_nxt = locked_p1;
        err_nxt    = 1'b0;
        wrap_nxt   = 1'b0;
        errcnt_nxt = errcnt_p1;

        if (valid) begin
            prev_nxt = count;
            case (state_p1)
                IDLE: begin
                    state_nxt = ACQUIRE;
                    match_nxt = '0;
                end
                ACQUIRE: begin
                    wrap_nxt = (count < prev_p1);
                    if (!legal) begin
                        match_nxt = '0;
                    end else if (match_p1 == '0 || diff != WIDTH'(cand_p1)) begin
                        cand_nxt  = diff[STEP_W-1:0];
                        match_nxt = MC_W'(1);
                    end else begin
                        match_nxt = match_p1 + MC_W'(1);
                    end
                    if (legal && match_nxt >= MC_W'(LOCK_COUNT)) begin
                        state_nxt  = LOCKED;
                        locked_nxt = 1'b1;
                        step_nxt   = cand_nxt;
                        miss_nxt   = '0;
                    end
                end
                LOCKED: begin
                    wrap_nxt = (count < prev_p1);
                    if (count == pred) begin
                        miss_nxt = '0;
                    end else begin
                        // prev still takes count, so the next prediction resyncs here
                        err_nxt    = 1'b1;
                        errcnt_nxt = sat_inc8(errcnt_p1);
                        miss_nxt   = miss_p1 + MS_W'(1);
                        if (miss_nxt >= MS_W'(ERR_LIMIT)) begin
                            state_nxt  = ACQUIRE;
                            locked_nxt = 1'b0;
                            step_nxt   = '0;
                            match_nxt  = '0;
                            miss_nxt   = '0;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Stage 1: registered state and outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p1  <= IDLE;
            prev_p1   <= '0;
            cand_p1   <= '0;
            match_p1  <= '0;
            miss_p1   <= '0;
            step_p1   <= '0;
            locked_p1 <= 1'b0;
            err_p1    <= 1'b0;
            wrap_p1   <= 1'b0;
            errcnt_p1 <= 8'd0;
        end else begin
            state_p1  <= state_nxt;
            prev_p1   <= prev_nxt;
            cand_p1   <= cand_nxt;
            match_p1  <= match_nxt;
            miss_p1   <= miss_nxt;
            step_p1   <= step_nxt;
            locked_p1 <= locked_nxt;
            err_p1    <= err_nxt;
            wrap_p1   <= wrap_nxt;
            errcnt_p1 <= errcnt_nxt;
        end
    end

    assign step      = step_p1;
    assign locked    = locked_p1;
    assign err       = err_p1;
    assign wrap      = wrap_p1;
    assign err_count = errcnt_p1;
    assign state     = state_p1;

endmodule

// File: tb/tb_count_monitor.sv
// Directed scoreboard bench for count_monitor: each driven cycle queues its
// expected registered outputs; a monitor pops and compares after every edge.
module tb_count_monitor;

    logic       clk;
    logic       reset;
    logic       valid;
    logic [4:0] count;
    logic [3:0] step;
    logic       locked;
    logic       err;
    logic       wrap;
    logic [7:0] err_count;
    logic [1:0] state;

    typedef struct packed {
        logic [1:0] st;
        logic       lk;
        logic [3:0] stp;
        logic       e;
        logic       w;
        logic [7:0] ec;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_m;
    exp_t act_m;
    int   n_vec = 0;
    int   n_bad = 0;

    count_monitor #(
        .WIDTH(5), .STEP_W(4), .LOCK_COUNT(3), .ERR_LIMIT(2)
    ) dut (
        .clk(clk), .reset(reset), .valid(valid), .count(count),
        .step(step), .locked(locked), .err(err), .wrap(wrap),
        .err_count(err_count), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic v, input logic [4:0] c,
                         input logic [1:0] st, input logic lk, input logic [3:0] stp,
                         input logic e, input logic w, input logic [7:0] ec);
        exp_t x;
        @(negedge clk);
        reset = r;
        valid = v;
        count = c;
        x.st = st; x.lk = lk; x.stp = stp; x.e = e; x.w = w; x.ec = ec;
        exp_q.push_back(x);
    endtask

    task automatic smp(input logic [4:0] c, input logic [1:0] st, input logic lk,
                       input logic [3:0] stp, input logic e, input logic w,
                       input logic [7:0] ec);
        drive(1'b0, 1'b1, c, st, lk, stp, e, w, ec);
    endtask

    task automatic gap(input int n, input logic [1:0] st, input logic lk,
                       input logic [3:0] stp, input logic [7:0] ec);
        for (int i = 0; i < n; i++)
            drive(1'b0, 1'b0, 5'd31, st, lk, stp, 1'b0, 1'b0, ec);
    endtask

    // Monitor: outputs are registered, so each queued entry is checked after the next edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_m = exp_q.pop_front();
                act_m.st = state; act_m.lk = locked; act_m.stp = step;
                act_m.e = err; act_m.w = wrap; act_m.ec = err_count;
                n_vec++;
                if (act_m !== exp_m) begin
                    n_bad++;
                    $display("FAIL vec%0d: got st=%0d lk=%0d step=%0d err=%0d wrap=%0d ec=%0d, want st=%0d lk=%0d step=%0d err=%0d wrap=%0d ec=%0d",
                             n_vec, act_m.st, act_m.lk, act_m.stp, act_m.e, act_m.w, act_m.ec,
                             exp_m.st, exp_m.lk, exp_m.stp, exp_m.e, exp_m.w, exp_m.ec);
                end
            end
        end
    end

    initial begin
        int p;
        logic [4:0] c;
        logic [7:0] ec;
        reset = 1'b1;
        valid = 1'b0;
        count = 5'd0;

        drive(1'b1, 1'b0, 5'd0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
        drive(1'b1, 1'b0, 5'd0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
        gap(2, 2'd0, 1'b0, 4'd0, 8'd0);

        // acquire and lock on step 4
        smp(5'd0,  2'd1, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
        smp(5'd4,  2'd1, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
        smp(5'd8,  2'd1, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
        smp(5'd12, 2'd2, 1'b1, 4'd4, 1'b0, 1'b0, 8'd0);
        smp(5'd16, 2'd2, 1'b1, 4'd4, 1'b0, 1'b0, 8'd0);

        // locked wrap through zero
        smp(5'd20, 2'd2, 1'b1, 4'd4, 1'b0, 1'b0, 8'd0);
        smp(5'd24, 2'd2, 1'b1, 4'd4, 1'b0, 1'b0, 8'd0);
        smp(5'd28, 2'd2, 1'b1, 4'd4, 1'b0, 1'b0, 8'd0);
        smp(5'd0,  2'd2, 1'b1, 4'd4, 1'b0, 1'b1, 8'd0);
        smp(5'd4,  2'd2, 1'b1, 4'd4, 1'b0, 1'b0, 8'd0);
        smp(5'd8,  2'd2, 1'b1, 4'd4, 1'b0, 1'b0, 8'd0);

        // single mismatch at prev=8, then resynced match
        smp(5'd13, 2'd2, 1'b1, 4'd4, 1'b1, 1'b0, 8'd1);
        gap(1, 2'd2, 1'b1, 4'd4, 8'd1);
        smp(5'd17, 2'd2, 1'b1, 4'd4, 1'b0, 1'b0, 8'd1);

        // two consecutive mismatches lose lock
        smp(5'd22, 2'd2, 1'b1, 4'd4, 1'b1, 1'b0, 8'd2);
        smp(5'd28, 2'd1, 1'b0, 4'd0, 1'b1, 1'b0, 8'd3);

        // relock with step 3, wrapping while in ACQUIRE
        smp(5'd31, 2'd1, 1'b0, 4'd0, 1'b0, 1'b0, 8'd3);
        smp(5'd2,  2'd1, 1'b0, 4'd0, 1'b0, 1'b1, 8'd3);
        smp(5'd5,  2'd2, 1'b1, 4'd3, 1'b0, 1'b0, 8'd3);
        smp(5'd8,  2'd2, 1'b1, 4'd3, 1'b0, 1'b0, 8'd3);

        // reset with valid while locked; next sample only loads prev
        drive(1'b1, 1'b1, 5'd11, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
        smp(5'd0,  2'd1, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
        gap(3, 2'd1, 1'b0, 4'd0, 8'd0);

        // illegal diffs (0, 20, 17) keep match count at zero
        smp(5'd0,  2'd1, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
        gap(3, 2'd1, 1'b0, 4'd0, 8'd0);
        smp(5'd0,  2'd1, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
        gap(3, 2'd1, 1'b0, 4'd0, 8'd0);
        smp(5'd20, 2'd1, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
        gap(3, 2'd1, 1'b0, 4'd0, 8'd0);
        smp(5'd5,  2'd1, 1'b0, 4'd0, 1'b0, 1'b1, 8'd0);
        gap(3, 2'd1, 1'b0, 4'd0, 8'd0);
        smp(5'd10, 2'd1, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
        gap(3, 2'd1, 1'b0, 4'd0, 8'd0);
        smp(5'd15, 2'd1, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
        gap(3, 2'd1, 1'b0, 4'd0, 8'd0);
        smp(5'd20, 2'd2, 1'b1, 4'd5, 1'b0, 1'b0, 8'd0);

        // err_count saturation: mismatch then match keeps lock, one err per pair
        p = 20;
        for (int i = 1; i <= 260; i++) begin
            ec = (i > 255) ? 8'd255 : 8'(i);
            c = 5'((p + 6) % 32);
            smp(c, 2'd2, 1'b1, 4'd5, 1'b1, (int'(c) < p), ec);
            p = int'(c);
            c = 5'((p + 5) % 32);
            smp(c, 2'd2, 1'b1, 4'd5, 1'b0, (int'(c) < p), ec);
            p = int'(c);
        end

        @(negedge clk);
        valid = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
